// File: rtl/chk_pkt_seq_mc.sv
// Multi-channel receive sequence checker: generates the outgoing sequence number and
// classifies returned sequence numbers per channel into in-order / lost / duplicate / backward.
module chk_pkt_seq_mc #(
    parameter int               NCH     = 4,
    parameter int               SEQ_W   = 16,
    parameter int               ERR_W   = 16,
    parameter int               TO_SEC  = 4,
    parameter logic [ERR_W-1:0] TO_CODE = 16'h0E0E
) (
    input  logic                 sysclk,
    input  logic                 nrst,
    input  logic                 tx_tri,
    output logic [SEQ_W-1:0]     pcnt,
    input  logic [NCH-1:0]       rx_vld,
    input  logic [NCH*SEQ_W-1:0] rx_seq,
    input  logic                 rst_err_cnt,
    input  logic                 sec_l,
    output logic [NCH*ERR_W-1:0] err_cnt,
    output logic [NCH*ERR_W-1:0] err_disp,
    output logic [NCH-1:0]       timeout,
    output logic [NCH-1:0]       synced,
    output logic [NCH-1:0]       err_evt
);

    typedef enum logic {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } ch_state_e;

    localparam int               SUM_W   = ((ERR_W > SEQ_W) ? ERR_W : SEQ_W) + 1;
    localparam logic [SUM_W-1:0] ERR_MAX = {{(SUM_W-ERR_W){1'b0}}, {ERR_W{1'b1}}};

    // Strobe edge detectors: edge = ~q[1] & q[0] of a 2-flop shift register.
    logic [1:0]     tx_q, rst_q, sec_q;
    logic [NCH-1:0] rx_q0, rx_q1;
    logic           tx_edge, rst_edge, sec_edge;
    logic [NCH-1:0] rx_edge;

    // NOTE: every clocked process uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            tx_q  <= '0;
            rst_q <= '0;
            sec_q <= '0;
            rx_q0 <= '0;
            rx_q1 <= '0;
        end else begin
            tx_q  <= {tx_q[0], tx_tri};
            rst_q <= {rst_q[0], rst_err_cnt};
            sec_q <= {sec_q[0], sec_l};
            rx_q0 <= rx_vld;
            rx_q1 <= rx_q0;
        end
    end

    assign tx_edge  = ~tx_q[1]  & tx_q[0];
    assign rst_edge = ~rst_q[1] & rst_q[0];
    assign sec_edge = ~sec_q[1] & sec_q[0];
    assign rx_edge  = ~rx_q1 & rx_q0;

    // Outgoing sequence number; only reset clears it.
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            pcnt <= '0;
        end else if (tx_edge) begin
            pcnt <= pcnt + SEQ_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_e        state, state_nxt;
        logic [SEQ_W-1:0] seq, last, d, add;
        logic             chk;
        logic [SUM_W-1:0] sum;
        logic [ERR_W-1:0] cnt;
        logic             evt;
        logic [TO_SEC-1:0] to_sr;

        assign seq = rx_seq[i*SEQ_W +: SEQ_W];

        always_ff @(posedge sysclk or negedge nrst) begin
            if (!nrst) begin
                state <= UNSYNC;
            end else begin
                state <= state_nxt;
            end
        end

        // NOTE: defaults first so every path assigns state_nxt and no latch is inferred.
        always_comb begin
            state_nxt = state;
            if (rst_edge) begin
                state_nxt = UNSYNC;
            end else if (rx_edge[i] && state == UNSYNC) begin
                state_nxt = SYNC;
            end
        end

        // Capture stage (cycle E): a packet arriving with a clear pending is discarded.
        always_ff @(posedge sysclk or negedge nrst) begin
            if (!nrst) begin
                last <= '0;
                d    <= '0;
                chk  <= 1'b0;
            end else begin
                chk <= 1'b0;
                if (rx_edge[i] && !rst_edge) begin
                    last <= seq;
                    if (state == SYNC) begin
                        d   <= seq - last;
                        chk <= 1'b1;
                    end
                end
            end
        end

        // Classification (cycle E+1): backward jumps count once; last already holds the new seq.
        always_comb begin
            add = '0;
            if (chk) begin
                if (d == '0 || d[SEQ_W-1]) begin
                    add = SEQ_W'(1);
                end else if (d != SEQ_W'(1)) begin
                    add = d - SEQ_W'(1);
                end
            end
        end

        assign sum = SUM_W'(cnt) + SUM_W'(add);

        always_ff @(posedge sysclk or negedge nrst) begin
            if (!nrst) begin
                cnt <= '0;
                evt <= 1'b0;
            end else if (rst_edge) begin
                cnt <= '0;
                evt <= 1'b0;
            end else begin
                evt <= (add != '0);
                if (add != '0) begin
                    cnt <= (sum > ERR_MAX) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
                end
            end
        end

        // Timeout shifter: any received packet outranks a same-cycle seconds tick.
        always_ff @(posedge sysclk or negedge nrst) begin
            if (!nrst) begin
                to_sr <= '0;
            end else if (rst_edge || rx_edge[i]) begin
                to_sr <= '0;
            end else if (sec_edge) begin
                to_sr <= TO_SEC'({to_sr, 1'b1});
            end
        end

        assign err_cnt[i*ERR_W +: ERR_W]  = cnt;
        assign err_disp[i*ERR_W +: ERR_W] = to_sr[TO_SEC-1] ? TO_CODE : cnt;
        assign timeout[i]                 = to_sr[TO_SEC-1];
        assign synced[i]                  = (state == SYNC);
        assign err_evt[i]                 = evt;
    end

endmodule

// File: tb/tb_chk_pkt_seq_mc.sv
// Directed bench for chk_pkt_seq_mc: a default instance plus a narrow instance
// (ERR_W=8, SEQ_W=12) used for saturation and sequence-number wrap.
module tb_chk_pkt_seq_mc;

    logic        sysclk = 1'b0;
    logic        nrst;
    logic        tx_tri, rst_err_cnt, sec_l;

    logic [15:0] pcnt;
    logic [3:0]  rx_vld;
    logic [63:0] rx_seq;
    logic [63:0] err_cnt, err_disp;
    logic [3:0]  timeout, synced, err_evt;

    logic [11:0] pcnt8;
    logic [3:0]  rx_vld8;
    logic [47:0] rx_seq8;
    logic [31:0] err_cnt8, err_disp8;
    logic [3:0]  timeout8, synced8, err_evt8;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 sysclk = ~sysclk;

    chk_pkt_seq_mc dut (
        .sysclk(sysclk), .nrst(nrst), .tx_tri(tx_tri), .pcnt(pcnt),
        .rx_vld(rx_vld), .rx_seq(rx_seq), .rst_err_cnt(rst_err_cnt), .sec_l(sec_l),
        .err_cnt(err_cnt), .err_disp(err_disp), .timeout(timeout),
        .synced(synced), .err_evt(err_evt)
    );

    chk_pkt_seq_mc #(.NCH(4), .SEQ_W(12), .ERR_W(8), .TO_SEC(4), .TO_CODE(8'h0E)) dut8 (
        .sysclk(sysclk), .nrst(nrst), .tx_tri(tx_tri), .pcnt(pcnt8),
        .rx_vld(rx_vld8), .rx_seq(rx_seq8), .rst_err_cnt(rst_err_cnt), .sec_l(sec_l),
        .err_cnt(err_cnt8), .err_disp(err_disp8), .timeout(timeout8),
        .synced(synced8), .err_evt(err_evt8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Returns at E+2, where err_cnt/err_evt for this packet are visible.
    task automatic send(input int ch, input logic [15:0] seq);
        rx_seq[ch*16 +: 16] = seq;
        rx_vld[ch] = 1'b1;
        tick();
        rx_vld[ch] = 1'b0;
        tick();
        tick();
    endtask

    task automatic send8(input int ch, input logic [11:0] seq);
        rx_seq8[ch*12 +: 12] = seq;
        rx_vld8[ch] = 1'b1;
        tick();
        rx_vld8[ch] = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_all(input logic [63:0] seqs);
        rx_seq = seqs;
        rx_vld = 4'hF;
        tick();
        rx_vld = 4'h0;
        tick();
        tick();
    endtask

    task automatic sec_pulse();
        sec_l = 1'b1;
        tick();
        sec_l = 1'b0;
        tick();
    endtask

    task automatic tx_pulse();
        tx_tri = 1'b1;
        tick();
        tx_tri = 1'b0;
        tick();
    endtask

    initial begin
        nrst = 1'b0;
        tx_tri = 1'b0; rst_err_cnt = 1'b0; sec_l = 1'b0;
        rx_vld = '0; rx_seq = '0; rx_vld8 = '0; rx_seq8 = '0;
        tick(); tick();
        check("rst_pcnt", 64'(pcnt), 64'd0);
        check("rst_err_cnt", err_cnt, 64'd0);
        check("rst_err_disp", err_disp, 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_synced", 64'(synced), 64'd0);
        check("rst_err_evt", 64'(err_evt), 64'd0);
        nrst = 1'b1;
        tick();

        // T1: in-order stream on ch0
        send(0, 16'd5);
        check("t1_synced0", 64'(synced[0]), 64'd1);
        check("t1_synced_others", 64'(synced[3:1]), 64'd0);
        send(0, 16'd6);
        check("t1_evt_6", 64'(err_evt[0]), 64'd0);
        send(0, 16'd7);
        send(0, 16'd8);
        check("t1_evt_8", 64'(err_evt[0]), 64'd0);
        check("t1_cnt0", 64'(err_cnt[15:0]), 64'd0);

        // T2: 11 -> 15 loses three packets
        send(1, 16'd10);
        send(1, 16'd11);
        check("t2_cnt1_inorder", 64'(err_cnt[31:16]), 64'd0);
        send(1, 16'd15);
        check("t2_cnt1_lost", 64'(err_cnt[31:16]), 64'd3);
        check("t2_evt1_pulse", 64'(err_evt[1]), 64'd1);
        tick();
        check("t2_evt1_end", 64'(err_evt[1]), 64'd0);

        // T3: duplicate, then 20 -> FFFF is a backward jump, then FFFF -> 0 wraps cleanly
        send(2, 16'd20);
        send(2, 16'd20);
        check("t3_cnt2_dup", 64'(err_cnt[47:32]), 64'd1);
        send(2, 16'hFFFF);
        check("t3_cnt2_back", 64'(err_cnt[47:32]), 64'd2);
        send(2, 16'h0000);
        check("t3_cnt2_wrap", 64'(err_cnt[47:32]), 64'd2);
        check("t3_evt2_wrap", 64'(err_evt[2]), 64'd0);

        // T4: backward then in order from the new reference
        send(3, 16'd100);
        send(3, 16'd50);
        check("t4_cnt3_back", 64'(err_cnt[63:48]), 64'd1);
        check("t4_evt3_back", 64'(err_evt[3]), 64'd1);
        send(3, 16'd51);
        check("t4_cnt3_resync", 64'(err_cnt[63:48]), 64'd1);
        check("t4_evt3_resync", 64'(err_evt[3]), 64'd0);

        // T5: 8-bit counter saturates on a 511-packet loss and stays there
        send8(0, 12'h000);
        send8(0, 12'h200);
        check("t5_sat", 64'(err_cnt8[7:0]), 64'hFF);
        check("t5_sat_evt", 64'(err_evt8[0]), 64'd1);
        send8(0, 12'h400);
        check("t5_sat_hold", 64'(err_cnt8[7:0]), 64'hFF);

        // T6: timeout after four seconds ticks
        sec_pulse(); sec_pulse(); sec_pulse();
        check("t6_to_3sec", 64'(timeout[0]), 64'd0);
        sec_pulse();
        check("t6_to_4sec", 64'(timeout[0]), 64'd1);
        check("t6_disp0", 64'(err_disp[15:0]), 64'h0E0E);
        check("t6_disp1", 64'(err_disp[31:16]), 64'h0E0E);
        check("t6_cnt0_kept", 64'(err_cnt[15:0]), 64'd0);
        check("t6_cnt1_kept", 64'(err_cnt[31:16]), 64'd3);
        check("t6_synced0_kept", 64'(synced[0]), 64'd1);
        check("t6_disp8", 64'(err_disp8[7:0]), 64'h0E);
        send(0, 16'd9);
        check("t6_to0_clear", 64'(timeout[0]), 64'd0);
        check("t6_disp0_clear", 64'(err_disp[15:0]), 64'd0);
        check("t6_to1_still", 64'(timeout[1]), 64'd1);

        // Lost packet (9 -> 20) whose E+1 cycle coincides with the clear edge
        rx_seq[15:0] = 16'd20;
        rx_vld[0] = 1'b1;
        tick();
        rx_vld[0] = 1'b0;
        rst_err_cnt = 1'b1;
        tick();
        rst_err_cnt = 1'b0;
        tick();
        check("t6_clr_cnt0", 64'(err_cnt[15:0]), 64'd0);
        check("t6_clr_evt0", 64'(err_evt[0]), 64'd0);
        check("t6_clr_synced", 64'(synced), 64'd0);
        check("t6_clr_all_cnt", err_cnt, 64'd0);
        check("t6_clr_timeout", 64'(timeout), 64'd0);
        check("t6_clr_cnt8", 64'(err_cnt8), 64'd0);

        // All channels in the same cycle: in-order, lost 1, duplicate, backward
        send_all({16'd4, 16'd3, 16'd2, 16'd1});
        check("par_synced", 64'(synced), 64'hF);
        check("par_sync_cnt", err_cnt, 64'd0);
        send_all({16'd1, 16'd3, 16'd4, 16'd2});
        check("par_cnt", err_cnt, {16'd1, 16'd1, 16'd1, 16'd0});
        check("par_evt", 64'(err_evt), 64'hE);

        // T7: outgoing sequence count and wrap of the 12-bit instance
        for (int k = 0; k < 16; k++) tx_pulse();
        check("t7_pcnt16", 64'(pcnt), 64'd16);
        check("t7_pcnt8_16", 64'(pcnt8), 64'd16);
        for (int k = 16; k < 4096; k++) tx_pulse();
        check("t7_pcnt8_wrap", 64'(pcnt8), 64'd0);
        check("t7_pcnt4096", 64'(pcnt), 64'd4096);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
